// File: rtl/btn_conditioner.sv
// btn_conditioner: three-button input stage.
// Each button goes through a 2-FF synchroniser, a debounce FSM with a stability
// counter, and a rising-edge one-shot. All outputs are registered.
// Optional auto-repeat of press pulses while held: define BTN_AUTOREPEAT_EN.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter bit          ACTIVE_LOW      = 1'b0,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn_raw,
    output logic [2:0] btn_level,
    output logic [2:0] btn_press,
    output logic       press_any,
    output logic [1:0] press_code
);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StHeld,
        StReleaseWait
    } db_state_e;

    // Count value on which the next stable sample completes the debounce window.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    // With a one-cycle window the first stable sample already qualifies.
    localparam bit SingleCycle = (DEBOUNCE_CYCLES <= 1);

    // Elaboration-time parameter sanity.
    if (DEBOUNCE_CYCLES < 1 || (64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt
        $error("btn_conditioner: CNT_W too small or DEBOUNCE_CYCLES zero");
    end
    if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_rep
        $error("btn_conditioner: repeat timing must be non-zero");
    end

    logic [2:0]       btn_in;
    logic [2:0]       s1_q, s2_q;
    db_state_e        state_q [3];
    db_state_e        state_d [3];
    logic [CNT_W-1:0] cnt_q   [3];
    logic [CNT_W-1:0] cnt_d   [3];
    logic [2:0]       level_q, level_d;
    logic [2:0]       accept;
    logic [2:0]       press_d, press_q;
    logic             any_d, any_q;
    logic [1:0]       code_d, code_q;

    assign btn_in = ACTIVE_LOW ? ~btn_raw : btn_raw;

    // Debounce next-state: counter and level per button.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            level_d[i] = level_q[i];
            accept[i]  = 1'b0;
            unique case (state_q[i])
                StIdle: begin
                    cnt_d[i] = '0;
                    if (s2_q[i]) begin
                        if (SingleCycle) begin
                            state_d[i] = StHeld;
                            level_d[i] = 1'b1;
                            accept[i]  = 1'b1;
                        end else begin
                            state_d[i] = StPressWait;
                            cnt_d[i]   = CNT_W'(1);
                        end
                    end
                end
                StPressWait: begin
                    if (!s2_q[i]) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntLast) begin
                        state_d[i] = StHeld;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b1;
                        accept[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                StHeld: begin
                    cnt_d[i] = '0;
                    if (!s2_q[i]) begin
                        if (SingleCycle) begin
                            state_d[i] = StIdle;
                            level_d[i] = 1'b0;
                        end else begin
                            state_d[i] = StReleaseWait;
                            cnt_d[i]   = CNT_W'(1);
                        end
                    end
                end
                StReleaseWait: begin
                    if (s2_q[i]) begin
                        // Release glitch: back to held without a new pulse.
                        state_d[i] = StHeld;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntLast) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = StIdle;
                    cnt_d[i]   = '0;
                    level_d[i] = 1'b0;
                end
            endcase
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RepW   = $clog2(RepMax + 1);

    logic [RepW-1:0] rep_q   [3];
    logic [RepW-1:0] rep_d   [3];
    logic [RepW-1:0] rep_inc [3];
    logic [RepW-1:0] rep_tgt [3];
    logic [2:0]      rep_first_q, rep_first_d;
    logic [2:0]      rep_fire;

    // Repeat timer: runs only while staying in a level-1 state, so entry into
    // HELD starts from zero and any exit to IDLE clears it.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rep_d[i]       = '0;
            rep_first_d[i] = 1'b0;
            rep_fire[i]    = 1'b0;
            rep_inc[i]     = rep_q[i] + 1'b1;
            rep_tgt[i]     = rep_first_q[i] ? RepW'(REPEAT_PERIOD) : RepW'(REPEAT_DELAY);
            if ((state_q[i] == StHeld || state_q[i] == StReleaseWait) &&
                (state_d[i] == StHeld || state_d[i] == StReleaseWait)) begin
                if (rep_inc[i] == rep_tgt[i]) begin
                    rep_fire[i]    = 1'b1;
                    rep_first_d[i] = 1'b1;
                end else begin
                    rep_d[i]       = rep_inc[i];
                    rep_first_d[i] = rep_first_q[i];
                end
            end
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) rep_q[i] <= '0;
            rep_first_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) rep_q[i] <= rep_d[i];
            rep_first_q <= rep_first_d;
        end
    end

    assign press_d = accept | rep_fire;
`else
    assign press_d = accept;
`endif

    // Press summary with fixed priority btn1 > btn2 > btn3.
    always_comb begin
        any_d  = |press_d;
        code_d = 2'd0;
        if (press_d[0]) begin
            code_d = 2'd1;
        end else if (press_d[1]) begin
            code_d = 2'd2;
        end else if (press_d[2]) begin
            code_d = 2'd3;
        end
    end

    // Synchroniser, debounce state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
            level_q <= '0;
            press_q <= '0;
            any_q   <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            s1_q    <= btn_in;
            s2_q    <= s1_q;
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            level_q <= level_d;
            press_q <= press_d;
            any_q   <= any_d;
            code_q  <= code_d;
        end
    end

    assign btn_level  = level_q;
    assign btn_press  = press_q;
    assign press_any  = any_q;
    assign press_code = code_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8).
module tb_btn_conditioner;

    logic       clk;
    logic       rst;
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic       press_any;
    logic [1:0] press_code;

    int n_checks;
    int n_fail;
    int press_cnt [3];
    int any_cnt;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .ACTIVE_LOW     (1'b0),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .press_any (press_any),
        .press_code(press_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) if (btn_press[i]) press_cnt[i] = press_cnt[i] + 1;
        if (press_any) any_cnt = any_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n clock edges, ending 1 time unit after the last edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int snap0, snap1, snap2, snap_any;
    logic exp_rep;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        any_cnt  = 0;
        for (int i = 0; i < 3; i++) press_cnt[i] = 0;
        rst     = 1'b1;
        btn_raw = 3'b000;

        // Reset state
        step(3);
        check_eq("rst_level", btn_level, 3'b000);
        check_eq("rst_press", btn_press, 3'b000);
        check_eq("rst_any", press_any, 1'b0);
        check_eq("rst_code", press_code, 2'd0);
        rst = 1'b0;
        step(3);

        // Basic press on btn1: sampled at edge k, accepted at edge k+5
        btn_raw = 3'b001;
        step(5);
        check_eq("b1_level_early", btn_level, 3'b000);
        check_eq("b1_press_early", btn_press, 3'b000);
        step(1);
        check_eq("b1_level", btn_level, 3'b001);
        check_eq("b1_press", btn_press, 3'b001);
        check_eq("b1_code", press_code, 2'd1);
        check_eq("b1_any", press_any, 1'b1);
        step(1);
        check_eq("b1_press_after", btn_press, 3'b000);
        check_eq("b1_level_after", btn_level, 3'b001);
        check_eq("b1_code_after", press_code, 2'd0);

        // Release btn1: level drops at edge k+5, no pulse
        snap0   = press_cnt[0];
        btn_raw = 3'b000;
        step(5);
        check_eq("b1_rel_early", btn_level, 3'b001);
        step(1);
        check_eq("b1_rel_level", btn_level, 3'b000);
        check_eq("b1_rel_nopulse", press_cnt[0], snap0);

        // Short bounces on btn2 are rejected
        step(4);
        snap_any = any_cnt;
        snap1    = press_cnt[1];
        for (int r = 0; r < 5; r++) begin
            btn_raw = 3'b010;
            step(3);
            check_eq("b2_bounce_level", btn_level, 3'b000);
            btn_raw = 3'b000;
            step(3);
        end
        step(4);
        check_eq("b2_bounce_level_end", btn_level, 3'b000);
        check_eq("b2_bounce_press", press_cnt[1], snap1);
        check_eq("b2_bounce_any", any_cnt, snap_any);

        // Simultaneous btn1 + btn3
        btn_raw = 3'b101;
        step(6);
        check_eq("sim_press", btn_press, 3'b101);
        check_eq("sim_code", press_code, 2'd1);
        check_eq("sim_any", press_any, 1'b1);
        check_eq("sim_level", btn_level, 3'b101);
        step(1);
        check_eq("sim_press_after", btn_press, 3'b000);
        check_eq("sim_any_after", press_any, 1'b0);
        btn_raw = 3'b000;
        step(8);
        check_eq("sim_rel_level", btn_level, 3'b000);

        // Release glitch while held, then a real release
        btn_raw = 3'b001;
        step(8);
        check_eq("gl_held", btn_level, 3'b001);
        snap0   = press_cnt[0];
        btn_raw = 3'b000;
        step(2);
        btn_raw = 3'b001;
        step(8);
        check_eq("gl_level", btn_level, 3'b001);
        check_eq("gl_nopulse", press_cnt[0], snap0);
        btn_raw = 3'b000;
        step(5);
        check_eq("gl_rel_early", btn_level, 3'b001);
        step(1);
        check_eq("gl_rel_level", btn_level, 3'b000);
        check_eq("gl_rel_nopulse", press_cnt[0], snap0);
        step(2);

        // Reset mid-debounce: btn3 held, btn1 two counts into its window
        btn_raw = 3'b100;
        step(8);
        check_eq("rm_pre_level", btn_level, 3'b100);
        btn_raw = 3'b101;
        step(4);
        rst = 1'b1;
        #2;
        check_eq("rm_async_level", btn_level, 3'b000);
        check_eq("rm_async_press", btn_press, 3'b000);
        step(1);
        rst = 1'b0;
        step(5);
        check_eq("rm_press_early", btn_press, 3'b000);
        check_eq("rm_level_early", btn_level, 3'b000);
        step(1);
        check_eq("rm_press", btn_press, 3'b101);
        check_eq("rm_code", press_code, 2'd1);
        check_eq("rm_level", btn_level, 3'b101);
        step(1);
        check_eq("rm_press_after", btn_press, 3'b000);
        btn_raw = 3'b000;
        step(8);
        check_eq("rm_rel_level", btn_level, 3'b000);

        // btn3 held 50 clocks after acceptance
        btn_raw = 3'b100;
        step(6);
        check_eq("hold_accept_press", btn_press, 3'b100);
        check_eq("hold_accept_code", press_code, 2'd3);
        for (int j = 1; j <= 50; j++) begin
            step(1);
`ifdef BTN_AUTOREPEAT_EN
            exp_rep = (j == 20 || j == 28 || j == 36 || j == 44);
`else
            exp_rep = 1'b0;
`endif
            check_eq("hold_press", btn_press, {exp_rep, 2'b00});
            check_eq("hold_code", press_code, exp_rep ? 2'd3 : 2'd0);
        end
        snap2 = press_cnt[2];
        btn_raw = 3'b000;
        step(8);
        check_eq("hold_rel_level", btn_level, 3'b000);
        check_eq("hold_rel_nopulse", press_cnt[2], snap2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
